binary_rank_filter: RTL and testbench

//  Parametrised successor to the 3x3 binary median stage. Accepts the WIN*WIN pixels of one window

---
 rtl/filter_pkg.sv | 27 ++
 rtl/rank_filter_skid.sv | 51 +++++
 rtl/binary_rank_filter.sv | 114 +++++++++++
 tb/tb_binary_rank_filter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// Shared definitions for the binary rank filter.
//   mode_e         : rank rule selected per window
//   win_pixels()   : pixels per window (WIN*WIN)
//   cnt_width()    : width able to hold the value WIN*WIN
//   centre_offset(): distance from the bottom-right pixel to the window centre
package filter_pkg;

   typedef enum logic [1:0] {
      MODE_MEDIAN = 2'd0,
      MODE_ERODE  = 2'd1,
      MODE_DILATE = 2'd2,
      MODE_THRESH = 2'd3
   } mode_e;

   function automatic int win_pixels(input int win);
      return win * win;
   endfunction

   function automatic int cnt_width(input int win);
      return $clog2(win * win + 1);
   endfunction

   function automatic int centre_offset(input int win);
      return win / 2;
   endfunction

endpackage

// File: rtl/rank_filter_skid.sv
// Two-entry result FIFO between the rank decision and the frame-buffer writer.
//   push/push_data : new result (ignored only when full and not popping)
//   pop_ready      : downstream accepts the head entry
//   pop_data       : head entry, stable while not popped
//   full/empty     : occupancy flags (occupancy held internally as count)
module rank_filter_skid #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop_ready,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   logic [1:0][W-1:0] mem;
   logic              wr_ptr, rd_ptr;
   logic [1:0]        count;
   logic              do_push, do_pop;

   assign empty    = (count == 2'd0);
   assign full     = (count == 2'd2);
   assign do_pop   = pop_ready && !empty;
   // A push into a full buffer is fine when the head leaves in the same cycle.
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem    <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) rd_ptr <= ~rd_ptr;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/binary_rank_filter.sv
// Binary rank filter: takes the WIN*WIN pixels of a window serially, counts
// the ones and applies a per-window rank rule (median/erode/dilate/threshold).
// One result per window, tagged with the window-centre address.
//   clk, reset (async, active low)
//   mode, threshold            : rank rule, latched on each window's first beat
//   inValid/inReady, inFirst, dataIn, xAddressIn, yAddressIn : pixel beats
//   outValid/outReady, dataOut, xMedianAddress, yMedianAddress : results
//   frameErr (sticky), errClear : window restarted before completion
module binary_rank_filter
   import filter_pkg::*;
#(
   parameter int WINDOW_SIZE = 3,
   parameter int ADDR_W      = 8,
   parameter int CNT_W       = cnt_width(WINDOW_SIZE)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        mode,
   input  logic [CNT_W-1:0]  threshold,
   input  logic              inValid,
   output logic              inReady,
   input  logic              inFirst,
   input  logic              dataIn,
   input  logic [ADDR_W-1:0] xAddressIn,
   input  logic [ADDR_W-1:0] yAddressIn,
   output logic              outValid,
   input  logic              outReady,
   output logic              dataOut,
   output logic [ADDR_W-1:0] xMedianAddress,
   output logic [ADDR_W-1:0] yMedianAddress,
   output logic              frameErr,
   input  logic              errClear
);

   localparam int                N     = win_pixels(WINDOW_SIZE);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0]  FULLC = CNT_W'(N);
   localparam logic [CNT_W-1:0]  HALF  = CNT_W'(N / 2);
   localparam logic [ADDR_W-1:0] OFS   = ADDR_W'(centre_offset(WINDOW_SIZE));
   localparam int                RW    = 1 + 2 * ADDR_W;

   logic [CNT_W-1:0] cnt, sum, sum_nxt, thr_q;
   mode_e            mode_q;
   logic             full, empty;
   logic             take, restart, win_start, last, decision;
   logic [RW-1:0]    res_in, res_out;

   // Gated by reset so the block advertises nothing while held in reset.
   assign inReady   = reset && !full;
   assign take      = inValid && inReady;
   assign restart   = take && inFirst && (cnt != '0);
   assign win_start = take && ((cnt == '0) || restart);
   assign last      = take && !restart && (cnt == LAST);
   assign sum_nxt   = sum + CNT_W'(dataIn);

   // Only evaluated on the last beat, which is never a window's first beat,
   // so the latched rule is always the one in force.
   always_comb begin
      decision = 1'b0;
      unique case (mode_q)
         MODE_MEDIAN: decision = (sum_nxt > HALF);
         MODE_ERODE:  decision = (sum_nxt == FULLC);
         MODE_DILATE: decision = (sum_nxt != '0);
         MODE_THRESH: decision = (sum_nxt >= thr_q);
         default:     decision = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt      <= '0;
         sum      <= '0;
         mode_q   <= MODE_MEDIAN;
         thr_q    <= '0;
         frameErr <= 1'b0;
      end else begin
         if (take) begin
            if (restart) begin
               cnt <= CNT_W'(1);
               sum <= CNT_W'(dataIn);
            end else if (last) begin
               cnt <= '0;
               sum <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
               sum <= sum_nxt;
            end
         end
         if (win_start) begin
            mode_q <= mode_e'(mode);
            thr_q  <= threshold;
         end
         // A new error wins over a simultaneous clear.
         frameErr <= (frameErr && !errClear) || restart;
      end
   end

   assign res_in = {decision, xAddressIn - OFS, yAddressIn - OFS};

   rank_filter_skid #(.W(RW)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .push      (last),
      .push_data (res_in),
      .pop_ready (outReady),
      .pop_data  (res_out),
      .full      (full),
      .empty     (empty)
   );

   assign outValid                                 = !empty;
   assign {dataOut, xMedianAddress, yMedianAddress} = res_out;

endmodule

// File: tb/tb_binary_rank_filter.sv
module tb_binary_rank_filter;
   import filter_pkg::*;

   localparam int WIN = 3,  N = 9,  AW = 8,  CW = 4;
   localparam int WIN5 = 5, N5 = 25, AW5 = 10, CW5 = 5;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   // WIN=3 instance
   logic [1:0]    mode = 2'd0;
   logic [CW-1:0] threshold = '0;
   logic          inValid = 1'b0, inFirst = 1'b0, dataIn = 1'b0;
   logic          outReady = 1'b1, errClear = 1'b0;
   logic [AW-1:0] xIn = '0, yIn = '0;
   logic          inReady, outValid, dataOut, frameErr;
   logic [AW-1:0] xMed, yMed;

   // WIN=5 instance
   logic [CW5-1:0] thr5 = '0;
   logic           v5 = 1'b0, f5 = 1'b0, d5 = 1'b0;
   logic [AW5-1:0] x5 = '0, y5 = '0;
   logic           rdy5, ov5, do5, fe5;
   logic [AW5-1:0] xo5, yo5;

   binary_rank_filter #(.WINDOW_SIZE(WIN), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .mode(mode), .threshold(threshold),
      .inValid(inValid), .inReady(inReady), .inFirst(inFirst), .dataIn(dataIn),
      .xAddressIn(xIn), .yAddressIn(yIn), .outValid(outValid), .outReady(outReady),
      .dataOut(dataOut), .xMedianAddress(xMed), .yMedianAddress(yMed),
      .frameErr(frameErr), .errClear(errClear));

   binary_rank_filter #(.WINDOW_SIZE(WIN5), .ADDR_W(AW5)) dut5 (
      .clk(clk), .reset(reset), .mode(2'd0), .threshold(thr5),
      .inValid(v5), .inReady(rdy5), .inFirst(f5), .dataIn(d5),
      .xAddressIn(x5), .yAddressIn(y5), .outValid(ov5), .outReady(1'b1),
      .dataOut(do5), .xMedianAddress(xo5), .yMedianAddress(yo5),
      .frameErr(fe5), .errClear(1'b0));

   int checks = 0, errors = 0;
   bit sb_on = 0, rnd_ready = 0;

   typedef struct { logic d; logic [AW-1:0] x, y; } res_t;
   res_t exp_q[$];

   typedef struct {
      logic [1:0] md; logic [CW-1:0] th; logic [N-1:0] pix;
      logic [AW-1:0] x, y; logic ed; logic [AW-1:0] ex, ey;
   } vec_t;
   vec_t tv[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic vec_t mkv(input int md, input int th, input int pix, input int x,
                                input int y, input int ed, input int ex, input int ey);
      vec_t v;
      v.md = 2'(md); v.th = CW'(th); v.pix = N'(pix); v.x = AW'(x); v.y = AW'(y);
      v.ed = 1'(ed); v.ex = AW'(ex); v.ey = AW'(ey);
      return v;
   endfunction

   // Reference: count the ones and apply the rule in plain arithmetic.
   function automatic res_t model(input int md, input int th, input logic [N-1:0] pix,
                                  input int x, input int y);
      res_t r;
      int ones = $countones(pix);
      case (md)
         0:       r.d = (2 * ones > N);
         1:       r.d = (ones == N);
         2:       r.d = (ones > 0);
         default: r.d = (ones >= th);
      endcase
      r.x = AW'((x - WIN / 2 + 256) % 256);
      r.y = AW'((y - WIN / 2 + 256) % 256);
      return r;
   endfunction

   // All stimulus changes happen at posedge+1.
   task automatic sync();
      @(posedge clk); #1;
      if (rnd_ready) outReady = 1'($urandom_range(0, 1));
   endtask

   task automatic send_beat(input logic d, input logic first, input logic [1:0] md,
                            input logic [CW-1:0] th, input logic [AW-1:0] x, input logic [AW-1:0] y);
      int n = 0;
      inValid = 1'b1; dataIn = d; inFirst = first; mode = md; threshold = th; xIn = x; yIn = y;
      forever begin
         @(negedge clk);
         if (inReady) break;
         n++;
         if (n > 300) begin
            errors++;
            $display("FAIL beat_timeout actual=stalled required=accepted");
            break;
         end
         @(posedge clk); #1;
         if (rnd_ready) outReady = 1'($urandom_range(0, 1));
      end
      sync();
      inValid = 1'b0; inFirst = 1'b0;
   endtask

   task automatic send_window(input int md, input int th, input logic [N-1:0] pix,
                              input int x, input int y, input bit first, input bit push);
      for (int i = 0; i < N; i++) begin
         // Rule inputs wander after the first beat; the DUT must ignore them.
         send_beat(pix[i], first && (i == 0),
                   (i == 0) ? 2'(md) : 2'($urandom_range(0, 3)),
                   (i == 0) ? CW'(th) : CW'($urandom_range(0, 15)),
                   (i == N - 1) ? AW'(x) : AW'($urandom),
                   (i == N - 1) ? AW'(y) : AW'($urandom));
      end
      if (push) exp_q.push_back(model(md, th, pix, x, y));
   endtask

   task automatic drain();
      int n = 0;
      rnd_ready = 0; outReady = 1'b1;
      while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      sync();
      @(negedge clk);
      chk("drain_outvalid", 32'(outValid), 32'd0);
      sync();
   endtask

   task automatic send_win5(input int ones, input int x, input int y);
      int n;
      for (int i = 0; i < N5; i++) begin
         v5 = 1'b1; d5 = (i < ones); f5 = (i == 0);
         x5 = (i == N5 - 1) ? AW5'(x) : AW5'(i);
         y5 = (i == N5 - 1) ? AW5'(y) : AW5'(i);
         n = 0;
         do begin @(negedge clk); n++; end while (!rdy5 && n < 300);
         @(posedge clk); #1;
      end
      v5 = 1'b0; f5 = 1'b0;
   endtask

   // Scoreboard on the WIN=3 output stream.
   always @(negedge clk) begin
      res_t e;
      if (sb_on && reset && outValid && outReady) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_extra actual=result required=none");
         end else begin
            e = exp_q.pop_front();
            chk("sb_data", 32'(dataOut), 32'(e.d));
            chk("sb_x", 32'(xMed), 32'(e.x));
            chk("sb_y", 32'(yMed), 32'(e.y));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      tv[0] = mkv(0, 0,  'h01F, 10,  20,  1, 9,   19);
      tv[1] = mkv(0, 0,  'h00F, 10,  20,  0, 9,   19);
      tv[2] = mkv(1, 0,  'h0FF, 5,   5,   0, 4,   4);
      tv[3] = mkv(1, 0,  'h1FF, 100, 7,   1, 99,  6);
      tv[4] = mkv(2, 0,  'h010, 0,   0,   1, 255, 255);
      tv[5] = mkv(2, 0,  'h000, 1,   1,   0, 0,   0);
      tv[6] = mkv(3, 0,  'h000, 255, 128, 1, 254, 127);
      tv[7] = mkv(3, 10, 'h1FF, 3,   4,   0, 2,   3);
      tv[8] = mkv(3, 9,  'h1FF, 8,   9,   1, 7,   8);
      tv[9] = mkv(0, 0,  'h1F0, 0,   50,  1, 255, 49);

      // Reset state
      #1;
      chk("rst_inready", 32'(inReady), 32'd0);
      chk("rst_outvalid", 32'(outValid), 32'd0);
      chk("rst_data", 32'(dataOut), 32'd0);
      chk("rst_x", 32'(xMed), 32'd0);
      chk("rst_y", 32'(yMed), 32'd0);
      chk("rst_ferr", 32'(frameErr), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rel_inready", 32'(inReady), 32'd1);
      sync();

      // Table: one window per vector, result expected the cycle after the last beat
      for (int i = 0; i < 10; i++) begin
         send_window(tv[i].md, tv[i].th, tv[i].pix, tv[i].x, tv[i].y, 1, 0);
         @(negedge clk);
         chk("tbl_valid", 32'(outValid), 32'd1);
         chk("tbl_data", 32'(dataOut), 32'(tv[i].ed));
         chk("tbl_x", 32'(xMed), 32'(tv[i].ex));
         chk("tbl_y", 32'(yMed), 32'(tv[i].ey));
         sync();
      end
      sb_on = 1;

      // Backpressure: two results buffered, third window stalls
      outReady = 1'b0;
      send_window(0, 0, 'h1FF, 30, 40, 1, 1);
      send_window(1, 0, 'h0FF, 50, 60, 1, 1);
      @(negedge clk);
      chk("bp_inready", 32'(inReady), 32'd0);
      chk("bp_outvalid", 32'(outValid), 32'd1);
      chk("bp_data", 32'(dataOut), 32'd1);
      sync();
      inValid = 1'b1; dataIn = 1'b0; inFirst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stall_inready", 32'(inReady), 32'd0);
         chk("stall_hold_x", 32'(xMed), 32'd29);
      end
      @(posedge clk); #1;
      outReady = 1'b1;
      send_window(2, 0, 'h010, 70, 80, 1, 1);
      drain();

      // Restart mid-window: partial window dropped, sticky error
      chk("err_init", 32'(frameErr), 32'd0);
      for (int i = 0; i < 4; i++) send_beat(1'b1, i == 0, 2'd0, '0, 8'd1, 8'd1);
      send_window(0, 0, 'h01F, 12, 34, 1, 1);
      @(negedge clk);
      chk("err_set", 32'(frameErr), 32'd1);
      sync();
      drain();
      // Second restart with errClear in the same cycle, error already set
      for (int i = 0; i < 4; i++) send_beat(1'b1, i == 0, 2'd0, '0, 8'd2, 8'd2);
      errClear = 1'b1;
      send_beat(1'b1, 1'b1, 2'd0, '0, 8'd3, 8'd3);
      errClear = 1'b0;
      @(negedge clk);
      chk("err_collide", 32'(frameErr), 32'd1);
      sync();
      for (int i = 1; i < N; i++) send_beat(1'b0, 1'b0, 2'd1, '0, AW'(i == N - 1 ? 60 : 0), 8'd70);
      exp_q.push_back(model(0, 0, 'h001, 60, 70));
      drain();
      errClear = 1'b1;
      sync();
      errClear = 1'b0;
      @(negedge clk);
      chk("err_clear", 32'(frameErr), 32'd0);
      sync();

      // Reset with a buffered result and a partial window
      outReady = 1'b0;
      send_window(0, 0, 'h1FF, 90, 90, 1, 0);
      for (int i = 0; i < 4; i++) send_beat(1'b1, i == 0, 2'd0, '0, 8'd5, 8'd5);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst2_outvalid", 32'(outValid), 32'd0);
      chk("rst2_inready", 32'(inReady), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      sync();
      outReady = 1'b1;
      send_window(0, 0, 'h00F, 77, 88, 1, 1);
      drain();

      // WIN=5, ADDR_W=10 build
      send_win5(13, 7, 3);
      @(negedge clk);
      chk("w5_valid", 32'(ov5), 32'd1);
      chk("w5_data13", 32'(do5), 32'd1);
      chk("w5_x", 32'(xo5), 32'd5);
      chk("w5_y", 32'(yo5), 32'd1);
      sync();
      send_win5(12, 1, 0);
      @(negedge clk);
      chk("w5_data12", 32'(do5), 32'd0);
      chk("w5_xwrap", 32'(xo5), 32'd1023);
      chk("w5_ywrap", 32'(yo5), 32'd1022);
      sync();

      // Random windows, random gaps and backpressure
      rnd_ready = 1;
      for (int w = 0; w < 40; w++) begin
         int md, th, x, y;
         logic [N-1:0] pix;
         md = int'($urandom_range(0, 3));
         th = int'($urandom_range(0, 15));
         x = int'($urandom_range(0, 255));
         y = int'($urandom_range(0, 255));
         pix = N'($urandom);
         send_window(md, th, pix, x, y, 1'($urandom_range(0, 1)), 1);
         repeat ($urandom_range(0, 2)) sync();
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
